pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the payload width of the datapath (ALU result, store data, branch target, concatenated).
REQ-002 Parameter CTRL_W, default 8, SHALL set the control-bit width (MemRead, MemWrite, Branch, RegWrite, MemToReg, zero flag, spares).
REQ-003 Parameter DEPTH, default 1, legal range 1..4, SHALL set the number of cascaded register stages.
REQ-004 clk  in  1  single clock; all state SHALL update on the falling edge, matching the pipeline registers it sits between.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 flush  in  1  kill all in-flight entries (branch mispredict, exception).
REQ-007 in_valid  in  1  upstream entry present.
REQ-008 in_ready  out  1  block accepts this cycle; registered output.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 out_valid  out  1  entry presented downstream.
REQ-012 out_ready  in  1  downstream accepts; deasserted = stall (replaces hit-gating).
REQ-013 out_data  out  DATA_W  head payload.
REQ-014 out_ctrl  out  CTRL_W  head control bits; SHALL be all-zero whenever out_valid=0.
REQ-015 occupancy  out  $clog2(2*DEPTH+1)  number of entries held.

Function
REQ-016 Each stage SHALL be a 2-entry skid buffer (main + skid register), so full throughput (one transfer per clock) is sustained with in_ready registered.
REQ-017 A transfer SHALL occur on a port when valid and ready are both 1 at the sampling edge; entries SHALL leave in arrival order with no loss or duplication.
REQ-018 Latency from an accepted input into an empty block to out_valid=1 SHALL be DEPTH falling edges.
REQ-019 Stage state SHALL be EMPTY (0 entries), HALF (main only) or FULL (main+skid); in_ready of a stage SHALL be 1 in EMPTY/HALF, 0 in FULL.
REQ-020 Stage transitions: EMPTY->HALF on push; HALF->FULL on push without pop; HALF->EMPTY on pop without push; HALF->HALF on push+pop; FULL->HALF on pop, skid moving into main.
REQ-021 When out_ready=0 with the block full, all contents SHALL hold unchanged indefinitely and in_ready SHALL be 0.
REQ-022 flush=1 SHALL, at that edge, clear every valid/skid bit and zero all ctrl registers; in_valid in the same cycle SHALL be dropped and out_ready ignored; occupancy SHALL read 0 the next cycle.
REQ-023 flush SHALL take priority over push, pop and stall when asserted simultaneously.
REQ-024 occupancy SHALL equal total held entries, incrementing on accept, decrementing on output transfer, unchanged on simultaneous accept+transfer, maximum 2*DEPTH.
REQ-025 Data registers need not be cleared; ctrl registers SHALL be zero for any invalid slot.

Reset
REQ-026 While rst_n=0 at a falling edge: all valid/skid bits 0, ctrl registers 0, occupancy 0, out_valid 0, in_ready 0.
REQ-027 in_ready SHALL rise on the first falling edge with rst_n=1; reset mid-operation SHALL discard all entries exactly as flush does.

Structure
REQ-028 A shared package SHALL hold the stage-state enum (EMPTY, HALF, FULL) and the MemRead..MemToReg ctrl bit-index constants.
REQ-029 One sub-module, pipe_skid_stage (DATA_W+CTRL_W payload), SHALL be instantiated DEPTH times via a generate loop; the top SHALL hold only chaining and occupancy logic.

Verification
REQ-030 DEPTH=1, reset then in_valid=1 with data 0x00000001..0x00000008 in consecutive cycles, out_ready=1 -> outputs 1..8 in order starting 1 edge later, in_ready continuously 1.
REQ-031 DEPTH=2, 6 pushes with out_ready=0 -> in_ready falls after the 4th accept, occupancy=4, contents held; out_ready=1 -> 4 entries drain in order, occupancy reaches 0.
REQ-032 DEPTH=3, full, flush=1 with in_valid=1 and ctrl=0xFF -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0, pushed entry absent.
REQ-033 Random valid/ready (50%) with 1000 items, DEPTH=1..4 -> scoreboard exact order match, occupancy always equals scoreboard count.
REQ-034 rst_n=0 for one edge while holding 3 entries -> all outputs at reset values, in_ready returns 1 one edge after rst_n=1.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline stage register and its skid stages.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StHalf,
    StFull
  } stage_state_e;

  // Bit positions of the control bits carried alongside the payload.
  localparam int unsigned CtrlMemRead  = 0;
  localparam int unsigned CtrlMemWrite = 1;
  localparam int unsigned CtrlBranch   = 2;
  localparam int unsigned CtrlRegWrite = 3;
  localparam int unsigned CtrlMemToReg = 4;
  localparam int unsigned CtrlZero     = 5;

endpackage

// File: rtl/pipe_skid_stage.sv
// One 2-entry skid buffer stage (main + skid register) with a registered in_ready.
// State updates on the falling clock edge; ctrl bits of any empty slot are held at zero.
module pipe_skid_stage
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W+CTRL_W-1:0] in_pld,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W+CTRL_W-1:0] out_pld
);

  localparam int unsigned PldW = DATA_W + CTRL_W;

  stage_state_e    state_q, state_d;
  logic [PldW-1:0] main_q, main_d;
  logic [PldW-1:0] skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  logic            push, pop;

  // Payload layout is {ctrl, data}; data may stay stale, ctrl must not.
  function automatic logic [PldW-1:0] kill_ctrl(input logic [PldW-1:0] p);
    return {{CTRL_W{1'b0}}, p[DATA_W-1:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    push    = in_valid & in_ready_q;
    pop     = (state_q != StEmpty) & out_ready;
    if (flush) begin
      state_d = StEmpty;
      main_d  = kill_ctrl(main_q);
      skid_d  = kill_ctrl(skid_q);
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            main_d  = in_pld;
            state_d = StHalf;
          end
        end
        StHalf: begin
          if (push && pop) begin
            main_d = in_pld;
          end else if (push) begin
            skid_d  = in_pld;
            state_d = StFull;
          end else if (pop) begin
            main_d  = kill_ctrl(main_q);
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = kill_ctrl(skid_q);
            state_d = StHalf;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    in_ready_d = (state_d != StFull);
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != StEmpty);
  assign out_pld   = main_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: DEPTH chained skid stages plus an occupancy counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DEPTH  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic [CTRL_W-1:0]              in_ctrl,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [CTRL_W-1:0]              out_ctrl,
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PldW = DATA_W + CTRL_W;
  localparam int unsigned OccW = $clog2(2*DEPTH+1);

  logic [DEPTH:0]  vld;
  logic [DEPTH:0]  rdy;
  logic [PldW-1:0] pld [DEPTH+1];

  assign vld[0]     = in_valid;
  assign pld[0]     = {in_ctrl, in_data};
  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_skid_stage #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (vld[i]),
      .in_ready (rdy[i]),
      .in_pld   (pld[i]),
      .out_valid(vld[i+1]),
      .out_ready(rdy[i+1]),
      .out_pld  (pld[i+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[DEPTH];
  assign out_data  = pld[DEPTH][DATA_W-1:0];
  assign out_ctrl  = pld[DEPTH][PldW-1:DATA_W];

  logic [OccW-1:0] occ_q, occ_d;
  logic            accept, xfer;

  assign accept = in_valid & rdy[0];
  assign xfer   = vld[DEPTH] & out_ready;

  // Internal stage-to-stage moves never change the total, only the block boundary does.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !xfer) begin
      occ_d = occ_q + OccW'(1);
    end else if (!accept && xfer) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DEPTH 1..4 instances share stimulus, each with its own scoreboard.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;

  logic        ir [4];
  logic        ov [4];
  logic [31:0] od [4];
  logic [7:0]  oc [4];
  logic [3:0]  occ [4];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change just after the active (falling) edge; checks run on the rising edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  for (genvar d = 0; d < 4; d++) begin : g
    localparam int unsigned OW = $clog2(2*(d+1)+1);
    logic [OW-1:0] occ_l;
    logic [39:0]   q[$];
    logic [39:0]   exp_v;

    pipe_stage_reg #(
      .DATA_W(32),
      .CTRL_W(8),
      .DEPTH (d+1)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (ir[d]),
      .in_data  (in_data),
      .in_ctrl  (in_ctrl),
      .out_valid(ov[d]),
      .out_ready(out_ready),
      .out_data (od[d]),
      .out_ctrl (oc[d]),
      .occupancy(occ_l)
    );

    assign occ[d] = 4'(occ_l);

    always @(posedge clk) begin
      if (chk_en) begin
        check($sformatf("d%0d_occ", d+1), 64'(occ_l), 64'(q.size()));
        if (!ov[d]) check($sformatf("d%0d_ctrl_idle", d+1), 64'(oc[d]), 64'd0);
        if (!rst_n || flush) begin
          q.delete();
        end else begin
          if (ov[d] && out_ready) begin
            check($sformatf("d%0d_nonempty", d+1), 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
              exp_v = q.pop_front();
              check($sformatf("d%0d_data", d+1), 64'({oc[d], od[d]}), 64'(exp_v));
            end
          end
          if (in_valid && ir[d]) q.push_back({in_ctrl, in_data});
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_ov%0d", tag, d+1), 64'(ov[d]), 64'd0);
      check($sformatf("%s_ir%0d", tag, d+1), 64'(ir[d]), 64'd0);
      check($sformatf("%s_occ%0d", tag, d+1), 64'(occ[d]), 64'd0);
      check($sformatf("%s_oc%0d", tag, d+1), 64'(oc[d]), 64'd0);
    end
  endtask

  task automatic check_all_ready(input string tag);
    for (int d = 0; d < 4; d++) check($sformatf("%s_ir%0d", tag, d+1), 64'(ir[d]), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;

    // Reset and release
    step();
    chk_en = 1'b1;
    step();
    @(posedge clk);
    check_reset_state("rst");
    step();
    rst_n = 1'b1;
    @(posedge clk);
    for (int d = 0; d < 4; d++) check($sformatf("rel_ir_low%0d", d+1), 64'(ir[d]), 64'd0);
    step();
    @(posedge clk);
    check_all_ready("rel");
    step();

    // DEPTH=1 streaming: outputs follow inputs by one edge, in_ready stays high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      in_ctrl  = 8'(i) | 8'(1 << CtrlRegWrite);
      @(posedge clk);
      check("stream_ir", 64'(ir[0]), 64'd1);
      if (i > 1) begin
        check("stream_ov", 64'(ov[0]), 64'd1);
        check("stream_od", 64'(od[0]), 64'(i - 1));
      end
      step();
    end
    in_valid = 1'b0;
    @(posedge clk);
    check("stream_last", 64'(od[0]), 64'd8);
    step();
    repeat (10) step();

    // DEPTH=2 backpressure: 4 accepts then stall, hold, then ordered drain
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(i);
      in_ctrl  = 8'(1 << CtrlMemWrite);
      @(posedge clk);
      check("bp_ir", 64'(ir[1]), 64'(i <= 4));
      step();
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      check("hold_ir", 64'(ir[1]), 64'd0);
      check("hold_occ", 64'(occ[1]), 64'd4);
      check("hold_od", 64'(od[1]), 64'h101);
      step();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      check("drain_ov", 64'(ov[1]), 64'd1);
      check("drain_od", 64'(od[1]), 64'h101 + 64'(j));
      step();
    end
    @(posedge clk);
    check("drain_occ", 64'(occ[1]), 64'd0);
    step();
    repeat (12) step();

    // DEPTH=3 flush while full, with a simultaneous push
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h200 + 32'(i);
      in_ctrl  = 8'(1 << CtrlMemRead) | 8'(1 << CtrlMemToReg);
      step();
    end
    @(posedge clk);
    check("full_occ", 64'(occ[2]), 64'd6);
    check("full_ir", 64'(ir[2]), 64'd0);
    step();
    flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'hFF; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; in_ctrl = 8'h00;
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("flush_ov%0d", d+1), 64'(ov[d]), 64'd0);
      check($sformatf("flush_oc%0d", d+1), 64'(oc[d]), 64'd0);
      check($sformatf("flush_occ%0d", d+1), 64'(occ[d]), 64'd0);
    end
    repeat (5) begin
      step();
      @(posedge clk);
      check("flush_absent", 64'(ov[2]), 64'd0);
    end
    step();

    // Reset mid-operation while holding entries
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h300 + 32'(i);
      in_ctrl  = 8'(1 << CtrlBranch);
      step();
    end
    in_valid = 1'b0;
    @(posedge clk);
    check("pre_rst_occ", 64'(occ[2]), 64'd3);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(posedge clk);
    check_reset_state("midrst");
    step();
    @(posedge clk);
    check_all_ready("midrel");
    step();

    // Random valid/ready with rare flushes; scoreboards check order and occupancy
    for (int c = 0; c < 4000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_ctrl   = 8'($urandom);
      flush     = ($urandom_range(0, 299) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("end_occ%0d", d+1), 64'(occ[d]), 64'd0);
      check($sformatf("end_ov%0d", d+1), 64'(ov[d]), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
